// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core's hazard and forwarding control:
// forward-select encoding, load-use FSM states and default widths.
package core_ctrl_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_IDX_W_DEF = 5;
  localparam int CNT_W_DEF     = 32;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_LOCK = 2'd3;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } lu_state_e;

endpackage

// File: rtl/operand_lock_slot.sv
// One EX operand: forward-select priority plus a lock register that keeps the
// WB-forwarded value alive while the pipeline is frozen.
module operand_lock_slot
  import core_ctrl_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ex_rs_index,
  input  logic [REG_IDX_W-1:0] mem_rd_index,
  input  logic                 mem_regfile_en,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic                 wb_regfile_en,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 pipe_freeze,
  output logic [1:0]           fwd_sel,
  output logic [XLEN-1:0]      lock_data
);

  logic       lock_valid;
  logic       mem_hit;
  logic       wb_hit;
  logic [1:0] sel;

  // x0 is hardwired zero, so a write to it must never be forwarded.
  assign mem_hit = mem_regfile_en && (mem_rd_index != '0) && (mem_rd_index == ex_rs_index);
  assign wb_hit  = wb_regfile_en && (wb_rd_index != '0) && (wb_rd_index == ex_rs_index);

  always_comb begin
    sel = FWD_RF;
    if (lock_valid) begin
      sel = FWD_LOCK;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  assign fwd_sel = rst ? sel : FWD_RF;

  // Capture only on the first frozen edge; later edges would see a retired WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_valid <= 1'b0;
      lock_data  <= '0;
    end else if (pipe_freeze) begin
      if (!lock_valid && (sel == FWD_WB)) begin
        lock_valid <= 1'b1;
        lock_data  <= wb_data;
      end
    end else begin
      lock_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use bubble insertion, EX operand forwarding selects and frozen-pipeline
// operand locks for the 5-stage core.
module hazard_forward_unit
  import core_ctrl_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_IDX_W = REG_IDX_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs1_index,
  input  logic [REG_IDX_W-1:0] id_rs2_index,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [REG_IDX_W-1:0] ex_rs1_index,
  input  logic [REG_IDX_W-1:0] ex_rs2_index,
  input  logic [REG_IDX_W-1:0] ex_rd_index,
  input  logic                 ex_is_load,
  input  logic                 ex_regfile_en,
  input  logic [REG_IDX_W-1:0] mem_rd_index,
  input  logic                 mem_regfile_en,
  input  logic [REG_IDX_W-1:0] wb_rd_index,
  input  logic                 wb_regfile_en,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 pipe_freeze,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_flush,
  output logic [1:0]           fwd_sel_rs1,
  output logic [1:0]           fwd_sel_rs2,
  output logic [XLEN-1:0]      lock_data_rs1,
  output logic [XLEN-1:0]      lock_data_rs2,
  output logic [CNT_W-1:0]     load_use_count
);

  lu_state_e  state;
  logic       hazard;
  logic       lu_stall;

  assign hazard = ex_is_load && ex_regfile_en && (ex_rd_index != '0) &&
                  ((id_rs1_used && (id_rs1_index == ex_rd_index)) ||
                   (id_rs2_used && (id_rs2_index == ex_rd_index)));

  // In LU_STALL the bubble sits in EX, so the stale hazard must be ignored.
  assign lu_stall   = rst && (state == IDLE) && hazard && !pipe_freeze;
  assign pc_stall   = lu_stall;
  assign ifid_stall = lu_stall;
  assign idex_flush = lu_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      load_use_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lu_stall) begin
            state <= LU_STALL;
            if (load_use_count != '1) begin
              load_use_count <= load_use_count + 1'b1;
            end
          end
        end
        LU_STALL: begin
          if (!pipe_freeze) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  operand_lock_slot #(
    .XLEN      (XLEN),
    .REG_IDX_W (REG_IDX_W)
  ) u_slot_rs1 (
    .clk            (clk),
    .rst            (rst),
    .ex_rs_index    (ex_rs1_index),
    .mem_rd_index   (mem_rd_index),
    .mem_regfile_en (mem_regfile_en),
    .wb_rd_index    (wb_rd_index),
    .wb_regfile_en  (wb_regfile_en),
    .wb_data        (wb_data),
    .pipe_freeze    (pipe_freeze),
    .fwd_sel        (fwd_sel_rs1),
    .lock_data      (lock_data_rs1)
  );

  operand_lock_slot #(
    .XLEN      (XLEN),
    .REG_IDX_W (REG_IDX_W)
  ) u_slot_rs2 (
    .clk            (clk),
    .rst            (rst),
    .ex_rs_index    (ex_rs2_index),
    .mem_rd_index   (mem_rd_index),
    .mem_regfile_en (mem_regfile_en),
    .wb_rd_index    (wb_rd_index),
    .wb_regfile_en  (wb_regfile_en),
    .wb_data        (wb_data),
    .pipe_freeze    (pipe_freeze),
    .fwd_sel        (fwd_sel_rs2),
    .lock_data      (lock_data_rs2)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: each step queues its expected
// outputs and the negedge monitor pops and compares them.
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_index, id_rs2_index;
  logic        id_rs1_used, id_rs2_used;
  logic [4:0]  ex_rs1_index, ex_rs2_index, ex_rd_index;
  logic        ex_is_load, ex_regfile_en;
  logic [4:0]  mem_rd_index;
  logic        mem_regfile_en;
  logic [4:0]  wb_rd_index;
  logic        wb_regfile_en;
  logic [31:0] wb_data;
  logic        pipe_freeze;
  logic        pc_stall, ifid_stall, idex_flush;
  logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0] lock_data_rs1, lock_data_rs2;
  logic [31:0] load_use_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        stall;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic [31:0] l1;
    logic [31:0] l2;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  hazard_forward_unit dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_index   (id_rs1_index),
    .id_rs2_index   (id_rs2_index),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .ex_rs1_index   (ex_rs1_index),
    .ex_rs2_index   (ex_rs2_index),
    .ex_rd_index    (ex_rd_index),
    .ex_is_load     (ex_is_load),
    .ex_regfile_en  (ex_regfile_en),
    .mem_rd_index   (mem_rd_index),
    .mem_regfile_en (mem_regfile_en),
    .wb_rd_index    (wb_rd_index),
    .wb_regfile_en  (wb_regfile_en),
    .wb_data        (wb_data),
    .pipe_freeze    (pipe_freeze),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .idex_flush     (idex_flush),
    .fwd_sel_rs1    (fwd_sel_rs1),
    .fwd_sel_rs2    (fwd_sel_rs2),
    .lock_data_rs1  (lock_data_rs1),
    .lock_data_rs2  (lock_data_rs2),
    .load_use_count (load_use_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_stall",   64'(pc_stall),       64'(e.stall));
      check("ifid_stall", 64'(ifid_stall),     64'(e.stall));
      check("idex_flush", 64'(idex_flush),     64'(e.stall));
      check("fwd_sel_rs1", 64'(fwd_sel_rs1),   64'(e.f1));
      check("fwd_sel_rs2", 64'(fwd_sel_rs2),   64'(e.f2));
      check("lock_rs1",   64'(lock_data_rs1),  64'(e.l1));
      check("lock_rs2",   64'(lock_data_rs2),  64'(e.l2));
      check("lu_count",   64'(load_use_count), 64'(e.cnt));
      $display("txn t=%0t stall=%0b f1=%0d f2=%0d l1=%08h l2=%08h cnt=%0d",
               $time, pc_stall, fwd_sel_rs1, fwd_sel_rs2, lock_data_rs1, lock_data_rs2, load_use_count);
    end
  end

  task automatic clear_inputs();
    id_rs1_index = '0; id_rs2_index = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1_index = '0; ex_rs2_index = '0; ex_rd_index = '0;
    ex_is_load = 1'b0; ex_regfile_en = 1'b0;
    mem_rd_index = '0; mem_regfile_en = 1'b0;
    wb_rd_index = '0; wb_regfile_en = 1'b0; wb_data = '0;
    pipe_freeze = 1'b0;
  endtask

  task automatic load_hazard_rs1();
    ex_is_load = 1'b1; ex_regfile_en = 1'b1; ex_rd_index = 5'd5;
    id_rs1_index = 5'd5; id_rs1_used = 1'b1;
  endtask

  task automatic step(input logic st, input logic [1:0] f1, input logic [1:0] f2,
                      input logic [31:0] l1, input logic [31:0] l2, input logic [31:0] cnt);
    exp_q.push_back('{st, f1, f2, l1, l2, cnt});
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("rst_stall", 64'(pc_stall), 64'd0);
    check("rst_count", 64'(load_use_count), 64'd0);
    check("rst_lock1", 64'(lock_data_rs1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Load-use on rs1, hazard held for two cycles to show LU_STALL ignores it.
    load_hazard_rs1();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    clear_inputs();
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 2);

    // rs2 path, with an unused but matching rs1.
    ex_is_load = 1'b1; ex_regfile_en = 1'b1; ex_rd_index = 5'd5;
    id_rs1_index = 5'd5; id_rs1_used = 1'b0; id_rs2_index = 5'd9; id_rs2_used = 1'b1;
    step(0, 0, 0, 0, 0, 2);
    id_rs2_index = 5'd5;
    step(1, 0, 0, 0, 0, 2);
    clear_inputs();
    step(0, 0, 0, 0, 0, 3);

    // Load that does not write rd is no hazard.
    load_hazard_rs1(); ex_regfile_en = 1'b0;
    step(0, 0, 0, 0, 0, 3);

    // x0 is never a hazard and never forwarded.
    clear_inputs();
    ex_is_load = 1'b1; ex_regfile_en = 1'b1; ex_rd_index = 5'd0; id_rs1_used = 1'b1;
    mem_regfile_en = 1'b1; mem_rd_index = 5'd0; wb_regfile_en = 1'b1; wb_rd_index = 5'd0;
    step(0, 0, 0, 0, 0, 3);

    // Forwarding priority.
    clear_inputs();
    mem_regfile_en = 1'b1; mem_rd_index = 5'd7; wb_regfile_en = 1'b1; wb_rd_index = 5'd7;
    ex_rs1_index = 5'd7; ex_rs2_index = 5'd7;
    step(0, 1, 1, 0, 0, 3);
    mem_regfile_en = 1'b0;
    step(0, 2, 2, 0, 0, 3);
    ex_rs1_index = 5'd4; wb_rd_index = 5'd4;
    step(0, 2, 0, 0, 0, 3);

    // Three-cycle freeze: capture on first edge only, WB data changes afterwards.
    clear_inputs();
    wb_regfile_en = 1'b1; wb_rd_index = 5'd3; wb_data = 32'hDEADBEEF;
    ex_rs1_index = 5'd3; pipe_freeze = 1'b1;
    step(0, 2, 0, 32'h0, 0, 3);
    wb_data = 32'h0;
    step(0, 3, 0, 32'hDEADBEEF, 0, 3);
    step(0, 3, 0, 32'hDEADBEEF, 0, 3);
    pipe_freeze = 1'b0;
    step(0, 3, 0, 32'hDEADBEEF, 0, 3);
    step(0, 2, 0, 32'hDEADBEEF, 0, 3);

    // One-cycle freeze on rs2: set and cleared on consecutive edges.
    ex_rs1_index = 5'd0; ex_rs2_index = 5'd3; wb_data = 32'h12345678; pipe_freeze = 1'b1;
    step(0, 0, 2, 32'hDEADBEEF, 32'h0, 3);
    pipe_freeze = 1'b0;
    step(0, 0, 3, 32'hDEADBEEF, 32'h12345678, 3);
    step(0, 0, 2, 32'hDEADBEEF, 32'h12345678, 3);

    // Freeze during hazard, and freeze holding LU_STALL.
    clear_inputs();
    load_hazard_rs1(); pipe_freeze = 1'b1;
    step(0, 0, 0, 32'hDEADBEEF, 32'h12345678, 3);
    pipe_freeze = 1'b0;
    step(1, 0, 0, 32'hDEADBEEF, 32'h12345678, 3);
    pipe_freeze = 1'b1;
    step(0, 0, 0, 32'hDEADBEEF, 32'h12345678, 4);
    pipe_freeze = 1'b0;
    step(0, 0, 0, 32'hDEADBEEF, 32'h12345678, 4);
    step(1, 0, 0, 32'hDEADBEEF, 32'h12345678, 4);
    clear_inputs();
    step(0, 0, 0, 32'hDEADBEEF, 32'h12345678, 5);

    // Async reset mid-LU_STALL with a lock held.
    load_hazard_rs1();
    ex_rs1_index = 5'd3; wb_regfile_en = 1'b1; wb_rd_index = 5'd3; wb_data = 32'hAAAA5555;
    step(1, 2, 0, 32'hDEADBEEF, 32'h12345678, 5);
    pipe_freeze = 1'b1;
    step(0, 2, 0, 32'hDEADBEEF, 32'h12345678, 6);
    check("pre_rst_fwd1", 64'(fwd_sel_rs1), 64'd3);
    check("pre_rst_lock1", 64'(lock_data_rs1), 64'hAAAA5555);
    #1;
    rst = 1'b0; pipe_freeze = 1'b0;
    #1;
    check("arst_stall", 64'(pc_stall), 64'd0);
    check("arst_flush", 64'(idex_flush), 64'd0);
    check("arst_fwd1", 64'(fwd_sel_rs1), 64'd0);
    check("arst_lock1", 64'(lock_data_rs1), 64'd0);
    check("arst_lock2", 64'(lock_data_rs2), 64'd0);
    check("arst_count", 64'(load_use_count), 64'd0);
    pipe_freeze = 1'b1;
    @(posedge clk);
    #1;
    check("rst_no_capture", 64'(lock_data_rs1), 64'd0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      check("queue_drained", 64'(exp_q.size()), 64'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
